// File: rtl/sd_cmd_host.sv
// Host-side SD command-line engine: divides i_clk down to sd_clk, serialises
// 48-bit commands (start, dir, index, arg, CRC7, end) onto CMD, then captures
// and checks the card's 48-bit or 136-bit response.
module sd_cmd_host #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [5:0]   i_cmd_index,
  input  logic [31:0]  i_cmd_arg,
  input  logic [1:0]   i_rsp_type,
  output logic         o_done,
  output logic [127:0] o_rsp_data,
  output logic         o_rsp_crc_err,
  output logic         o_rsp_timeout,
  output logic         o_sd_clk,
  output logic         o_sd_cmd_o,
  output logic         o_sd_cmd_t,
  input  logic         i_sd_cmd
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT_RSP,
    ST_RX,
    ST_GAP
  } state_e;

  // One CRC7 (x^7 + x^3 + 1) shift step for a single serial bit.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int unsigned i = 0; i < 40; i++) c = crc7_step(c, d[39-i]);
    return c;
  endfunction

  function automatic logic [6:0] crc7_120(input logic [119:0] d);
    logic [6:0] c;
    c = '0;
    for (int unsigned i = 0; i < 120; i++) c = crc7_step(c, d[119-i]);
    return c;
  endfunction

  // Divider state
  logic [DIV_W-1:0] div_q, div_d;
  logic             sd_clk_q, sd_clk_d;
  logic             wrap, fall_en, rise_en;

  // Engine state
  state_e           state_q, state_d;
  logic [47:0]      frame_q, frame_d;
  logic [1:0]       type_q, type_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [135:0]     sr_q, sr_d;
  logic             cmd_o_q, cmd_o_d;
  logic             cmd_t_q, cmd_t_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [127:0]     rsp_data_q, rsp_data_d;
  logic             crc_err_q, crc_err_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       rx_len;

  // sd_clk divider: toggle on counter wrap, strobes mark the toggle cycle.
  always_comb begin
    wrap     = (div_q == DIV_W'(CLK_DIV - 1));
    div_d    = wrap ? '0 : div_q + 1'b1;
    sd_clk_d = wrap ? ~sd_clk_q : sd_clk_q;
    fall_en  = wrap & sd_clk_q;
    rise_en  = wrap & ~sd_clk_q;
  end

  // Command/response FSM next-state and datapath.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    type_d     = type_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sr_d       = sr_q;
    cmd_o_d    = cmd_o_q;
    cmd_t_d    = cmd_t_q;
    done_d     = 1'b0;
    rsp_data_d = rsp_data_q;
    crc_err_d  = crc_err_q;
    timeout_d  = timeout_q;
    rx_len     = (type_q == 2'b10) ? 8'd136 : 8'd48;

    unique case (state_q)
      ST_IDLE: begin
        cmd_o_d = 1'b1;
        cmd_t_d = 1'b1;
        if (i_cmd_valid && ready_q) begin
          frame_d    = {2'b01, i_cmd_index, i_cmd_arg,
                        crc7_40({2'b01, i_cmd_index, i_cmd_arg}), 1'b1};
          type_d     = i_rsp_type;
          bit_cnt_d  = '0;
          rsp_data_d = '0;
          crc_err_d  = 1'b0;
          timeout_d  = 1'b0;
          state_d    = ST_TX;
        end
      end

      // Frame is shifted out MSB first; a 49th fall_en ends the last bit period.
      ST_TX: begin
        if (fall_en) begin
          if (bit_cnt_q < 8'd48) begin
            cmd_o_d   = frame_q[47];
            cmd_t_d   = 1'b0;
            frame_d   = {frame_q[46:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 8'd1;
          end else begin
            cmd_o_d    = 1'b1;
            cmd_t_d    = 1'b1;
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            if (type_q == 2'b00) begin
              gap_cnt_d = '0;
              done_d    = 1'b1;
              state_d   = ST_GAP;
            end else begin
              state_d = ST_WAIT_RSP;
            end
          end
        end
      end

      ST_WAIT_RSP: begin
        if (rise_en) begin
          if (!i_sd_cmd) begin
            // Start bit is 0, so a cleared shifter already holds it.
            sr_d      = '0;
            bit_cnt_d = 8'd1;
            state_d   = ST_RX;
          end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            gap_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = ST_GAP;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end

      ST_RX: begin
        if (rise_en) begin
          sr_d      = {sr_q[134:0], i_sd_cmd};
          bit_cnt_d = bit_cnt_q + 8'd1;
          if (bit_cnt_q == rx_len - 8'd1) begin
            if (type_q == 2'b10) begin
              rsp_data_d = {sr_d[127:1], 1'b0};
              crc_err_d  = (crc7_120(sr_d[127:8]) != sr_d[7:1]) | ~sr_d[0];
            end else begin
              rsp_data_d = {90'b0, sr_d[45:8]};
              crc_err_d  = ((type_q == 2'b01) && (crc7_40(sr_d[47:8]) != sr_d[7:1]))
                           | ~sr_d[0];
            end
            gap_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        cmd_o_d = 1'b1;
        cmd_t_d = 1'b1;
        if (fall_en) begin
          if (gap_cnt_q == 4'd7) state_d = ST_IDLE;
          else                   gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q      <= '0;
      sd_clk_q   <= 1'b0;
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      type_q     <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      sr_q       <= '0;
      cmd_o_q    <= 1'b1;
      cmd_t_q    <= 1'b1;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      rsp_data_q <= '0;
      crc_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      sd_clk_q   <= sd_clk_d;
      state_q    <= state_d;
      frame_q    <= frame_d;
      type_q     <= type_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sr_q       <= sr_d;
      cmd_o_q    <= cmd_o_d;
      cmd_t_q    <= cmd_t_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rsp_data_q <= rsp_data_d;
      crc_err_q  <= crc_err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_sd_clk      = sd_clk_q;
  assign o_sd_cmd_o    = cmd_o_q;
  assign o_sd_cmd_t    = cmd_t_q;
  assign o_cmd_ready   = ready_q;
  assign o_done        = done_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_crc_err = crc_err_q;
  assign o_rsp_timeout = timeout_q;

endmodule

// File: tb/tb_sd_cmd_host.sv
// Bench for sd_cmd_host: a behavioural SD card captures command frames and
// answers with scripted responses; expected frames and results are queued
// when each command is issued and popped as the DUT produces them.
module tb_sd_cmd_host;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_cmd_valid = 1'b0;
  logic         o_cmd_ready;
  logic [5:0]   i_cmd_index = '0;
  logic [31:0]  i_cmd_arg = '0;
  logic [1:0]   i_rsp_type = '0;
  logic         o_done;
  logic [127:0] o_rsp_data;
  logic         o_rsp_crc_err;
  logic         o_rsp_timeout;
  logic         o_sd_clk;
  logic         o_sd_cmd_o;
  logic         o_sd_cmd_t;
  logic         sd_pad;
  logic         card_drv = 1'b1;

  always #5 clk = ~clk;

  // Pull-up bus: host wins while driving, otherwise the card's value.
  assign sd_pad = o_sd_cmd_t ? card_drv : o_sd_cmd_o;

  sd_cmd_host #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_index(i_cmd_index), .i_cmd_arg(i_cmd_arg), .i_rsp_type(i_rsp_type),
    .o_done(o_done), .o_rsp_data(o_rsp_data),
    .o_rsp_crc_err(o_rsp_crc_err), .o_rsp_timeout(o_rsp_timeout),
    .o_sd_clk(o_sd_clk), .o_sd_cmd_o(o_sd_cmd_o), .o_sd_cmd_t(o_sd_cmd_t),
    .i_sd_cmd(sd_pad)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    logic         crc_err;
    logic         timeout;
  } rsp_t;

  rsp_t        exp_rsp_q[$];
  logic [47:0] exp_frame_q[$];
  logic [135:0] rsp_bits = '0;
  int unsigned  rsp_len = 0;
  int unsigned  card_bits = 0;
  rsp_t         got_r;

  // Reference CRC7 over the low n bits of d, MSB first.
  function automatic logic [6:0] ref_crc7(input logic [119:0] d, input int unsigned n);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int unsigned i = 0; i < n; i++) begin
      fb = c[6] ^ d[n-1-i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, ref_crc7({80'b0, h}, 40), 1'b1};
  endfunction

  // Simulated card: capture a frame on sd_clk rising edges, then answer.
  initial begin : card
    logic [47:0] fr;
    logic aborted;
    forever begin
      @(posedge o_sd_clk);
      if (rst_n && !o_sd_cmd_t && !o_sd_cmd_o) begin
        fr = '0;
        card_bits = 1;
        aborted = 1'b0;
        while (card_bits < 48) begin
          @(posedge o_sd_clk or negedge rst_n);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          fr = {fr[46:0], sd_pad};
          card_bits++;
        end
        card_bits = 0;
        if (!aborted) begin
          if (exp_frame_q.size() == 0) check("frame_unexpected", 1, 0);
          else check("tx_frame", {88'b0, fr}, {88'b0, exp_frame_q.pop_front()});
          if (rsp_len != 0) begin
            repeat (5) @(negedge o_sd_clk);
            for (int i = int'(rsp_len) - 1; i >= 0; i--) begin
              card_drv = rsp_bits[i];
              @(negedge o_sd_clk);
            end
            card_drv = 1'b1;
          end
        end
      end
    end
  end

  // Result checker: pop the expected result on every o_done pulse.
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      if (exp_rsp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        got_r = exp_rsp_q.pop_front();
        check("rsp_data", {8'b0, o_rsp_data}, {8'b0, got_r.data});
        check("rsp_crc_err", {135'b0, o_rsp_crc_err}, {135'b0, got_r.crc_err});
        check("rsp_timeout", {135'b0, o_rsp_timeout}, {135'b0, got_r.timeout});
        @(negedge clk);
        check("done_one_cycle", {135'b0, o_done}, 0);
        check("rsp_hold", {7'b0, o_rsp_data, o_rsp_crc_err},
              {7'b0, got_r.data, got_r.crc_err});
      end
    end
  end

  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!o_cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_cmd", {135'b0, o_cmd_ready}, 1);
    i_cmd_index = idx;
    i_cmd_arg   = arg;
    i_rsp_type  = typ;
    i_cmd_valid = 1'b1;
    @(negedge clk);
    check("ready_drop", {135'b0, o_cmd_ready}, 0);
    check("rsp_cleared", {6'b0, o_rsp_data, o_rsp_crc_err, o_rsp_timeout}, 0);
    // Request while busy with different contents must be ignored.
    i_cmd_index = 6'h3F;
    i_cmd_arg   = $urandom;
    i_rsp_type  = 2'b10;
    repeat (10) @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_complete(input string tag);
    int unsigned n;
    n = 0;
    while ((exp_rsp_q.size() != 0 || !o_cmd_ready) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {135'b0, (n < 20000)}, 1);
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                         input logic [47:0] frame, input logic [135:0] rbits,
                         input int unsigned rlen, input logic [127:0] edata,
                         input logic ecrc, input logic eto, input string tag);
    rsp_t r;
    r.data = edata;
    r.crc_err = ecrc;
    r.timeout = eto;
    rsp_bits = rbits;
    rsp_len  = rlen;
    exp_frame_q.push_back(frame);
    exp_rsp_q.push_back(r);
    send(idx, arg, typ);
    wait_complete(tag);
  endtask

  logic [119:0] cid;
  logic [6:0]   cid_crc;
  logic [47:0]  r8;
  logic [47:0]  fr41;
  int unsigned  n;

  initial begin
    // Reset values while held in reset.
    #23;
    check("rst_sd_clk", {135'b0, o_sd_clk}, 0);
    check("rst_cmd_o", {135'b0, o_sd_cmd_o}, 1);
    check("rst_cmd_t", {135'b0, o_sd_cmd_t}, 1);
    check("rst_ready", {135'b0, o_cmd_ready}, 0);
    check("rst_outs", {6'b0, o_done, o_rsp_data, o_rsp_crc_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_at_release", {135'b0, o_cmd_ready}, 0);
    @(negedge clk);
    check("ready_after_rst", {135'b0, o_cmd_ready}, 1);

    // CMD0, no response.
    run_cmd(6'd0, 32'h0, 2'b00, 48'h400000000095, '0, 0, '0, 1'b0, 1'b0, "cmd0_complete");

    // CMD8 with clean R7.
    r8 = 48'h08000001AA13;
    run_cmd(6'd8, 32'h000001AA, 2'b01, 48'h48000001AA87, {88'b0, r8}, 48,
            {90'b0, 6'h08, 32'h000001AA}, 1'b0, 1'b0, "cmd8_complete");

    // CMD8 with one argument bit flipped by the card.
    r8 = 48'h08000001AA13 ^ 48'h000000000200;
    run_cmd(6'd8, 32'h000001AA, 2'b01, 48'h48000001AA87, {88'b0, r8}, 48,
            {90'b0, 6'h08, 32'h000001A8}, 1'b1, 1'b0, "cmd8_bad_complete");

    // CMD17 with a silent card.
    run_cmd(6'd17, 32'h0, 2'b01, 48'h510000000055, '0, 0, '0, 1'b0, 1'b1, "cmd17_timeout_complete");

    // CMD2 with a 136-bit R2 carrying a valid CRC.
    cid     = 120'h035344534133324780123456780148;
    cid_crc = ref_crc7(cid, 120);
    run_cmd(6'd2, 32'h0, 2'b10, 48'h42000000004D, {2'b00, 6'h3F, cid, cid_crc, 1'b1}, 136,
            {cid, cid_crc, 1'b0}, 1'b0, 1'b0, "cmd2_complete");

    // ACMD41 with R3: CRC field all ones, no check.
    fr41 = mk_frame(6'd41, 32'h40FF8000);
    run_cmd(6'd41, 32'h40FF8000, 2'b11, fr41, {88'b0, 2'b00, 6'h3F, 32'hC0FF8000, 7'h7F, 1'b1}, 48,
            {90'b0, 6'h3F, 32'hC0FF8000}, 1'b0, 1'b0, "acmd41_complete");

    // Reset in the middle of a CMD0 transmission.
    exp_frame_q.push_back(48'h400000000095);
    exp_rsp_q.push_back('{data: '0, crc_err: 1'b0, timeout: 1'b0});
    rsp_len = 0;
    send(6'd0, 32'h0, 2'b00);
    n = 0;
    while (card_bits < 20 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit20", {135'b0, (card_bits >= 20)}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cmd_t", {135'b0, o_sd_cmd_t}, 1);
    check("midrst_cmd_o", {135'b0, o_sd_cmd_o}, 1);
    check("midrst_outs", {5'b0, o_sd_clk, o_cmd_ready, o_done, o_rsp_data}, 0);
    exp_frame_q.delete();
    exp_rsp_q.delete();
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);

    // Fresh CMD0 after reset.
    run_cmd(6'd0, 32'h0, 2'b00, 48'h400000000095, '0, 0, '0, 1'b0, 1'b0, "cmd0_after_rst_complete");

    check("frames_drained", {104'b0, exp_frame_q.size()}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

endmodule
